// File: rtl/t05_data_mem_responder_pkg.sv
// Shared types, constants and lane helpers for the data-memory responder.
package t05_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  // Access is rejected for misalignment, an unknown size, or an unsigned store.
  function automatic logic access_bad(input logic [2:0] f3, input logic [1:0] lo,
                                      input logic is_store);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_BU:   bad = is_store;
      F3_H:    bad = lo[0];
      F3_HU:   bad = is_store | lo[0];
      F3_W:    bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte-lane enables for an access of the given size at the given offset.
  function automatic logic [3:0] lane_sel(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] sel;
    sel = 4'b0000;
    case (f3)
      F3_B, F3_BU: sel = 4'b0001 << lo;
      F3_H, F3_HU: sel = 4'b0011 << lo;
      F3_W:        sel = 4'b1111;
      default:     sel = 4'b0000;
    endcase
    return sel;
  endfunction

  // Store data replicated across all lanes so any enabled lane carries it.
  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    w = d;
    case (f3)
      F3_B, F3_BU: w = {4{d[7:0]}};
      F3_H, F3_HU: w = {2{d[15:0]}};
      default:     w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/t05_load_extend.sv
// Picks the addressed byte/half from a bus word and sign- or zero-extends it.
module t05_load_extend
  import t05_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select followed by size/sign extension.
  always_comb begin
    byte_v = rdata[7:0];
    case (addr)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = addr[1] ? rdata[31:16] : rdata[15:0];
    data   = rdata;
    case (funct3)
      F3_B:    data = {{24{byte_v[7]}}, byte_v};
      F3_BU:   data = {24'h00_0000, byte_v};
      F3_H:    data = {{16{half_v[15]}}, half_v};
      F3_HU:   data = {16'h0000, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/t05_data_mem_responder.sv
// Single-outstanding load/store responder between the core datapath and the data bus.
module t05_data_mem_responder
  import t05_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] read_address,
  input  logic [31:0] write_address,
  input  logic [31:0] store_data,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  output logic        bus_we,
  output logic        bus_stb,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        stall,
  output logic        fault
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       sel_q, sel_d;
  logic             we_q, we_d;
  logic             stb_q, stb_d;
  logic [31:0]      ldata_q, ldata_d;
  logic             lvalid_q, lvalid_d;
  logic             fault_q, fault_d;
  logic [1:0]       lo_q, lo_d;
  logic [2:0]       f3_q, f3_d;

  logic             req;
  logic [31:0]      req_addr;
  logic [31:0]      ext_data;

  assign req      = mem_read | mem_write;
  assign req_addr = mem_write ? write_address : read_address;

  t05_load_extend u_load_extend (
    .rdata  (bus_rdata),
    .addr   (lo_q),
    .funct3 (f3_q),
    .data   (ext_data)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    sel_d    = sel_q;
    we_d     = we_q;
    stb_d    = stb_q;
    ldata_d  = ldata_q;
    lvalid_d = 1'b0;
    fault_d  = 1'b0;
    lo_d     = lo_q;
    f3_d     = f3_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = req_addr & WORD_ALIGN_MASK;
          wdata_d = lane_wdata(funct3, store_data);
          sel_d   = lane_sel(funct3, req_addr[1:0]);
          we_d    = mem_write;
          lo_d    = req_addr[1:0];
          f3_d    = funct3;
          cnt_d   = '0;
          if (access_bad(funct3, req_addr[1:0], mem_write)) begin
            state_d = ST_ERR;
            fault_d = 1'b1;
            stb_d   = 1'b0;
          end else begin
            state_d = ST_BUSY;
            stb_d   = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (bus_ack) begin
          state_d = ST_RESP;
          stb_d   = 1'b0;
          if (!we_q) begin
            ldata_d  = ext_data;
            lvalid_d = 1'b1;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_ERR;
          stb_d   = 1'b0;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      stb_q    <= 1'b0;
      ldata_q  <= '0;
      lvalid_q <= 1'b0;
      fault_q  <= 1'b0;
      lo_q     <= '0;
      f3_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      stb_q    <= stb_d;
      ldata_q  <= ldata_d;
      lvalid_q <= lvalid_d;
      fault_q  <= fault_d;
      lo_q     <= lo_d;
      f3_q     <= f3_d;
    end
  end

  // Stall is raised in the request cycle itself, so it must be combinational.
  assign stall = (state_q == ST_BUSY) | ((state_q == ST_IDLE) & req);

  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign bus_sel    = sel_q;
  assign bus_we     = we_q;
  assign bus_stb    = stb_q;
  assign load_data  = ldata_q;
  assign load_valid = lvalid_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_t05_data_mem_responder.sv
// Directed bench for the data-memory responder with a transaction-level reference.
module tb_t05_data_mem_responder;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] read_address, write_address, store_data;
  logic [31:0] bus_addr, bus_wdata, bus_rdata, load_data;
  logic [3:0]  bus_sel;
  logic        bus_we, bus_stb, bus_ack, load_valid, stall, fault;

  t05_data_mem_responder #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .read_address(read_address), .write_address(write_address), .store_data(store_data),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_sel(bus_sel), .bus_we(bus_we),
    .bus_stb(bus_stb), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .load_data(load_data),
    .load_valid(load_valid), .stall(stall), .fault(fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Expected outputs for the current cycle.
  bit          chk_en = 0, chk_rst = 0;
  logic        exp_stall, exp_stb, exp_lv, exp_fault, exp_we;
  logic [31:0] exp_addr, exp_wdata, exp_ld;
  logic [3:0]  exp_sel;

  // Observation counters used by the literal checks.
  int stall_cnt = 0, stb_cnt = 0, lv_cnt = 0, fault_cnt = 0;
  logic [31:0] seen_ld, seen_wdata, seen_addr;
  logic [3:0]  seen_sel;
  logic        seen_we;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference rules written directly from the access-size table.
  function automatic bit ref_bad(input logic [2:0] f3, input logic [1:0] lo, input bit st);
    if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1;
    if (st && (f3 == 3'b100 || f3 == 3'b101)) return 1;
    if ((f3 == 3'b001 || f3 == 3'b101) && lo[0]) return 1;
    if (f3 == 3'b010 && lo != 0) return 1;
    return 0;
  endfunction

  function automatic logic [3:0] ref_sel(input logic [2:0] f3, input logic [1:0] lo);
    int n;
    n = (f3 == 3'b010) ? 4 : ((f3[1:0] == 2'b01) ? 2 : 1);
    if (n == 4) return 4'hF;
    return 4'(((1 << n) - 1) << lo);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'b010) return d;
    if (f3[1:0] == 2'b01) return (d & 32'hFFFF) * 32'h0001_0001;
    return (d & 32'hFF) * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] ref_ext(input logic [31:0] r, input logic [1:0] lo,
                                          input logic [2:0] f3);
    logic [31:0] b, h;
    b = (r >> (8 * lo)) & 32'hFF;
    h = (r >> (16 * lo[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'b101:  return h;
      default: return r;
    endcase
  endfunction

  // Mid-cycle compare of the DUT against the expected values, then advance one clock.
  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      chk("stall", stall, exp_stall);
      chk("bus_stb", bus_stb, exp_stb);
      chk("load_valid", load_valid, exp_lv);
      chk("fault", fault, exp_fault);
      if (exp_stb) begin
        chk("bus_addr", bus_addr, exp_addr);
        chk("bus_sel", bus_sel, exp_sel);
        chk("bus_we", bus_we, exp_we);
        if (exp_we) chk("bus_wdata", bus_wdata, exp_wdata);
      end
      if (exp_lv) chk("load_data", load_data, exp_ld);
      if (chk_rst) begin
        chk("rst_addr", bus_addr, 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_sel", bus_sel, 0);
        chk("rst_we", bus_we, 0);
        chk("rst_load_data", load_data, 0);
      end
    end
    if (stall === 1'b1) stall_cnt++;
    if (fault === 1'b1) fault_cnt++;
    if (load_valid === 1'b1) begin
      lv_cnt++;
      seen_ld = load_data;
    end
    if (bus_stb === 1'b1) begin
      stb_cnt++;
      seen_addr = bus_addr;
      seen_sel = bus_sel;
      seen_we = bus_we;
      seen_wdata = bus_wdata;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_exp();
    exp_stall = 0; exp_stb = 0; exp_lv = 0; exp_fault = 0;
  endtask

  // One full instruction: request, bus phase (ack on BUSY cycle ack_k, 0 = never), retire.
  task automatic run_txn(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] sd,
                         input int ack_k, input logic [31:0] rdat);
    logic [31:0] a;
    bit bad, done;
    a = wr ? wa : ra;
    bad = ref_bad(f3, a[1:0], wr);
    mem_read = rd; mem_write = wr; funct3 = f3;
    read_address = ra; write_address = wa; store_data = sd;
    idle_exp(); exp_stall = 1;
    tick();
    mem_read = 0; mem_write = 0;
    if (bad) begin
      idle_exp(); exp_fault = 1;
      tick();
    end else begin
      exp_addr = a & 32'hFFFF_FFFC;
      exp_sel = ref_sel(f3, a[1:0]);
      exp_we = wr;
      exp_wdata = ref_wdata(f3, sd);
      done = 0;
      for (int j = 1; j <= TIMEOUT && !done; j++) begin
        idle_exp(); exp_stb = 1; exp_stall = 1;
        bus_ack = (j == ack_k);
        bus_rdata = (j == ack_k) ? rdat : 32'h5A5A_0000 + 32'(j);
        tick();
        bus_ack = 0;
        if (j == ack_k) begin
          done = 1;
          idle_exp(); exp_lv = !wr;
          exp_ld = ref_ext(rdat, a[1:0], f3);
          tick();
        end
      end
      if (!done) begin
        idle_exp(); exp_fault = 1;
        tick();
      end
    end
    idle_exp();
    tick();
  endtask

  int s_stall, s_stb, s_lv, s_fault;
  task automatic snap();
    s_stall = stall_cnt; s_stb = stb_cnt; s_lv = lv_cnt; s_fault = fault_cnt;
  endtask

  initial begin
    rst = 1; mem_read = 0; mem_write = 0; funct3 = 0;
    read_address = 0; write_address = 0; store_data = 0;
    bus_rdata = 0; bus_ack = 0;
    idle_exp();
    tick();
    chk_en = 1; chk_rst = 1;
    tick();
    rst = 0;
    tick();
    chk_rst = 0;

    // LW with ack on the third BUSY cycle.
    snap();
    run_txn(1, 0, 3'b010, 32'h0000_1004, 0, 0, 3, 32'hDEAD_BEEF);
    chk("lw_data", seen_ld, 32'hDEAD_BEEF);
    chk("lw_addr", seen_addr, 32'h0000_1004);
    chk("lw_sel", seen_sel, 4'b1111);
    chk("lw_we", seen_we, 0);
    chk("lw_stall_cycles", stall_cnt - s_stall, 4);
    chk("lw_lv_cycles", lv_cnt - s_lv, 1);

    // LB / LBU at offset 3.
    run_txn(1, 0, 3'b000, 32'h0000_2003, 0, 0, 1, 32'h80FF_FF7F);
    chk("lb_data", seen_ld, 32'hFFFF_FF80);
    run_txn(1, 0, 3'b100, 32'h0000_2003, 0, 0, 2, 32'h80FF_FF7F);
    chk("lbu_data", seen_ld, 32'h0000_0080);

    // LH / LHU upper half.
    run_txn(1, 0, 3'b001, 32'h0000_3002, 0, 0, 1, 32'h8001_1234);
    chk("lh_data", seen_ld, 32'hFFFF_8001);
    run_txn(1, 0, 3'b101, 32'h0000_3002, 0, 0, 1, 32'h8001_1234);
    chk("lhu_data", seen_ld, 32'h0000_8001);

    // SH at offset 2.
    snap();
    run_txn(0, 1, 3'b001, 0, 32'h0000_4002, 32'h1234_ABCD, 2, 0);
    chk("sh_sel", seen_sel, 4'b1100);
    chk("sh_wdata", seen_wdata, 32'hABCD_ABCD);
    chk("sh_we", seen_we, 1);
    chk("sh_lv_cycles", lv_cnt - s_lv, 0);

    // SB at offset 1.
    run_txn(0, 1, 3'b000, 0, 32'h0000_4001, 32'h0000_0055, 1, 0);
    chk("sb_sel", seen_sel, 4'b0010);
    chk("sb_wdata", seen_wdata, 32'h5555_5555);

    // Misaligned LW, bad funct3, unsigned store.
    snap();
    run_txn(1, 0, 3'b010, 32'h0000_5001, 0, 0, 1, 0);
    chk("mis_stb_cycles", stb_cnt - s_stb, 0);
    chk("mis_fault_cycles", fault_cnt - s_fault, 1);
    chk("mis_stall_cycles", stall_cnt - s_stall, 1);
    snap();
    run_txn(1, 0, 3'b011, 32'h0000_5000, 0, 0, 1, 0);
    run_txn(0, 1, 3'b100, 0, 32'h0000_5000, 32'h1, 1, 0);
    chk("badf3_fault_cycles", fault_cnt - s_fault, 2);

    // Timeout: no ack, then ack on the last allowed BUSY cycle.
    snap();
    run_txn(1, 0, 3'b010, 32'h0000_0100, 0, 0, 0, 0);
    chk("to_stb_cycles", stb_cnt - s_stb, 16);
    chk("to_fault_cycles", fault_cnt - s_fault, 1);
    snap();
    run_txn(1, 0, 3'b010, 32'h0000_0100, 0, 0, 16, 32'h0BAD_CAFE);
    chk("to_edge_fault", fault_cnt - s_fault, 0);
    chk("to_edge_data", seen_ld, 32'h0BAD_CAFE);

    // Ack while idle is ignored.
    snap();
    bus_ack = 1; bus_rdata = 32'hFFFF_FFFF; idle_exp();
    tick();
    bus_ack = 0;
    tick();
    chk("idle_ack_lv", lv_cnt - s_lv, 0);

    // Reset while BUSY, then a late ack.
    snap();
    mem_read = 1; funct3 = 3'b010; read_address = 32'h0000_0040;
    idle_exp(); exp_stall = 1;
    tick();
    mem_read = 0;
    exp_stb = 1; exp_addr = 32'h40; exp_sel = 4'hF; exp_we = 0;
    tick();
    rst = 1;
    tick();
    rst = 0; idle_exp(); chk_rst = 1;
    tick();
    chk_rst = 0; bus_ack = 1; bus_rdata = 32'h1111_2222;
    tick();
    bus_ack = 0;
    tick();
    chk("rst_busy_lv", lv_cnt - s_lv, 0);
    chk("rst_busy_fault", fault_cnt - s_fault, 0);

    // Simultaneous read and write: the store wins.
    run_txn(1, 1, 3'b010, 32'h0000_3001, 32'h0000_2000, 32'hCAFE_F00D, 1, 0);
    chk("both_we", seen_we, 1);
    chk("both_addr", seen_addr, 32'h0000_2000);
    chk("both_wdata", seen_wdata, 32'hCAFE_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
